gtech_ao22_rr_mux: RTL and testbench
====================================

Name: gtech_ao22_rr_mux

Overview:
- Two-source arbitrated data merge stage.
- Generates the one-hot select pair that drives a two-input AND-OR (AO22) data merge: Z_next = (DATA0 & G0) | (DATA1 & G1), replicated per bit.
- Registers the merged word into a single-entry output holding register with a valid/ready handshake.
- Sits between two independent producers and one consumer in the generic-cell datapath.

Parameters:
- WIDTH, 8, data width of DATA0, DATA1 and Z.

Ports:
- CP, input, 1, clock; all state changes on its rising edge.
- RST, input, 1, asynchronous active-high reset.
- REQ0, input, 1, source 0 valid.
- DATA0, input, WIDTH, source 0 data.
- RDY0, output, 1, source 0 accepted this cycle.
- REQ1, input, 1, source 1 valid.
- DATA1, input, WIDTH, source 1 data.
- RDY1, output, 1, source 1 accepted this cycle.
- Z, output, WIDTH, registered merged data.
- ZV, output, 1, Z valid.
- ZR, input, 1, consumer ready.
- GSRC, output, 1, source index of the word currently held in Z.

Behaviour:
- Reset (RST=1, asynchronous, held until deassertion): Z=0, ZV=0, GSRC=0, PRI=0. RDY0 and RDY1 are forced to 0 while RST=1.
- PRI is the internal round-robin pointer: PRI=0 favours source 0; PRI=1 favours source 1.
- ACC = !ZV | ZR (combinational). The register can load when it is empty or is being drained in the same cycle.
- Grant, combinational, one-hot or zero:
  - REQ0 only -> G0.
  - REQ1 only -> G1.
  - Both -> G0 if PRI=0, else G1.
  - Neither -> no grant.
- RDY0 = G0 & ACC; RDY1 = G1 & ACC. Grant never depends on RDYx (no combinational loop).
- Transfer from source i occurs when REQi & RDYi at the clock edge.
- Output register state machine:
  - EMPTY (ZV=0):
    - Transfer -> FULL. Load Z = AO22 merge, GSRC = granted index.
    - No transfer -> stay EMPTY. Z and GSRC hold their last values.
  - FULL (ZV=1):
    - ZR=1 and transfer -> stay FULL, load the new word (back-to-back, 1 word per cycle).
    - ZR=1, no transfer -> EMPTY.
    - ZR=0 -> hold Z, GSRC and ZV. RDY0 = RDY1 = 0.
- PRI update:
  - On each transfer, PRI = the non-granted index (1 after a G0 transfer, 0 after a G1 transfer).
  - No transfer -> PRI holds.
  - PRI updates only on an actual transfer, not on a grant that is blocked by ZR=0.
- Latency: source handshake to ZV=1 is 1 cycle. With ZR tied high, throughput is 1 word per cycle.
- Fairness: with both sources requesting continuously, grants alternate strictly. Neither source waits more than 1 transfer.
- Sources must hold REQ and DATA stable until RDY. The block does not check this.
- Reset mid-transfer: the held word is discarded, ZV drops immediately (asynchronously), and PRI returns to 0.
- No X propagation: Z loads only on a transfer.

Test Plan:
- Reset: assert RST with ZV=1, Z=8'hA5 -> Z=0, ZV=0, RDY0=RDY1=0 immediately; after release with REQ0=REQ1=0 -> ZV stays 0.
- Single source: REQ0=1, DATA0=8'h3C, ZR=1 -> RDY0=1 in cycle 0; next cycle Z=8'h3C, ZV=1, GSRC=0; PRI=1.
- Contention: REQ0=REQ1=1 continuously, DATA0=8'h11, DATA1=8'h22, ZR=1 -> Z sequence 11,22,11,22…; GSRC sequence 0,1,0,1; RDY0 and RDY1 never both 1.
- Backpressure: register FULL with 8'h11, ZR=0 for 3 cycles, REQ1=1 -> RDY1=0, Z=8'h11 held, PRI unchanged; ZR=1 -> same-cycle RDY1=1, next cycle Z=8'h22.
- Drain to empty: FULL, ZR=1, no REQ -> ZV=0 next cycle, Z holds last value.
- Async reset during contention mid-stream -> ZV=0 without a clock edge; after release, first contention grant goes to source 0.

Source files
------------

// File: rtl/gtech_ao22_rr_mux.sv
// Two-source round-robin arbiter feeding an AO22 data merge into a single-entry
// output holding register with a valid/ready handshake toward one consumer.
module gtech_ao22_rr_mux #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CP,
    input  logic             RST,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] DATA0,
    output logic             RDY0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] DATA1,
    output logic             RDY1,
    output logic [WIDTH-1:0] Z,
    output logic             ZV,
    input  logic             ZR,
    output logic             GSRC
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic             pri;
    logic [WIDTH-1:0] z_q;
    logic             gsrc_q;

    logic             acc;
    logic             g0;
    logic             g1;
    logic             xfer0;
    logic             xfer1;
    logic             xfer;
    logic [WIDTH-1:0] merge;

    // Grant depends only on requests and the pointer, never on RDYx.
    always_comb begin
        acc   = (state == EMPTY) | ZR;
        g0    = REQ0 & (~REQ1 | ~pri);
        g1    = REQ1 & (~REQ0 |  pri);
        RDY0  = g0 & acc & ~RST;
        RDY1  = g1 & acc & ~RST;
        xfer0 = REQ0 & RDY0;
        xfer1 = REQ1 & RDY1;
        xfer  = xfer0 | xfer1;
        merge = (DATA0 & {WIDTH{g0}}) | (DATA1 & {WIDTH{g1}});
    end

    // Output register FSM; pointer moves to the loser only on a real transfer.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            state  <= EMPTY;
            pri    <= 1'b0;
            z_q    <= '0;
            gsrc_q <= 1'b0;
        end else begin
            if (xfer) begin
                z_q    <= merge;
                gsrc_q <= xfer1;
                pri    <= xfer0;
            end
            case (state)
                EMPTY: begin
                    if (xfer) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (ZR && !xfer) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign Z    = z_q;
    assign ZV   = (state == FULL);
    assign GSRC = gsrc_q;

endmodule

// File: tb/tb_gtech_ao22_rr_mux.sv
// Directed bench for gtech_ao22_rr_mux: a reference model predicts grants and
// queues each accepted word, which is popped when the output register loads.
module tb_gtech_ao22_rr_mux;

    localparam int unsigned WIDTH = 8;

    logic             CP;
    logic             RST;
    logic             REQ0;
    logic [WIDTH-1:0] DATA0;
    logic             RDY0;
    logic             REQ1;
    logic [WIDTH-1:0] DATA1;
    logic             RDY1;
    logic [WIDTH-1:0] Z;
    logic             ZV;
    logic             ZR;
    logic             GSRC;

    int checks;
    int failures;

    typedef struct {
        logic             src;
        logic [WIDTH-1:0] data;
    } sb_t;

    sb_t              sb_q[$];
    logic             m_zv;
    logic             m_pri;
    logic [WIDTH-1:0] m_z;
    logic             m_gsrc;

    gtech_ao22_rr_mux #(.WIDTH(WIDTH)) dut (
        .CP(CP), .RST(RST),
        .REQ0(REQ0), .DATA0(DATA0), .RDY0(RDY0),
        .REQ1(REQ1), .DATA1(DATA1), .RDY1(RDY1),
        .Z(Z), .ZV(ZV), .ZR(ZR), .GSRC(GSRC)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_zv   = 1'b0;
        m_pri  = 1'b0;
        m_z    = '0;
        m_gsrc = 1'b0;
        sb_q.delete();
    endtask

    // One clock: drive, check handshake, clock, check register against model.
    task automatic cycle(input logic r0, input logic [WIDTH-1:0] d0,
                         input logic r1, input logic [WIDTH-1:0] d1,
                         input logic zr, input string tag);
        logic acc, e0, e1;
        sb_t  ent;
        @(negedge CP);
        REQ0 = r0; DATA0 = d0; REQ1 = r1; DATA1 = d1; ZR = zr;
        #1;
        acc = ~m_zv | zr;
        e0 = 1'b0;
        e1 = 1'b0;
        if (r0 && r1) begin
            if (m_pri) e1 = acc; else e0 = acc;
        end else if (r0) begin
            e0 = acc;
        end else if (r1) begin
            e1 = acc;
        end
        chk({tag, ".rdy0"}, WIDTH'(RDY0), WIDTH'(e0));
        chk({tag, ".rdy1"}, WIDTH'(RDY1), WIDTH'(e1));
        if (e0) sb_q.push_back('{src: 1'b0, data: d0});
        if (e1) sb_q.push_back('{src: 1'b1, data: d1});
        @(posedge CP);
        #1;
        if (e0 || e1) begin
            if (sb_q.size() > 0) begin
                ent    = sb_q.pop_front();
                m_z    = ent.data;
                m_gsrc = ent.src;
                m_pri  = ~ent.src;
            end
            m_zv = 1'b1;
        end else if (zr) begin
            m_zv = 1'b0;
        end
        chk({tag, ".zv"}, WIDTH'(ZV), WIDTH'(m_zv));
        chk({tag, ".z"}, Z, m_z);
        chk({tag, ".gsrc"}, WIDTH'(GSRC), WIDTH'(m_gsrc));
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge.
    task automatic async_reset(input string tag);
        @(negedge CP);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        chk({tag, ".zv"}, WIDTH'(ZV), 8'h00);
        chk({tag, ".z"}, Z, 8'h00);
        chk({tag, ".gsrc"}, WIDTH'(GSRC), 8'h00);
        chk({tag, ".rdy0"}, WIDTH'(RDY0), 8'h00);
        chk({tag, ".rdy1"}, WIDTH'(RDY1), 8'h00);
        @(posedge CP);
        #1;
        chk({tag, ".zv_held"}, WIDTH'(ZV), 8'h00);
        @(negedge CP);
        #2;
        RST = 1'b0;
        REQ0 = 1'b0;
        REQ1 = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        RST = 1'b1;
        REQ0 = 1'b0; DATA0 = '0; REQ1 = 1'b0; DATA1 = '0; ZR = 1'b0;
        model_reset();
        #12;
        chk("por.zv", WIDTH'(ZV), 8'h00);
        chk("por.z", Z, 8'h00);
        chk("por.rdy0", WIDTH'(RDY0), 8'h00);
        RST = 1'b0;

        // Fill with A5 under backpressure, then reset while full and requesting.
        cycle(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, "fill");
        @(negedge CP);
        REQ0 = 1'b1; DATA0 = 8'h77; ZR = 1'b0;
        async_reset("rst_full");
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "idle_a");
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "idle_b");

        // Single source, then drain to empty (Z holds).
        cycle(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, "single");
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "drain");
        cycle(1'b0, 8'h00, 1'b1, 8'h55, 1'b1, "src1");

        // Continuous contention alternates strictly, ending full with 11.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, $sformatf("cont%0d", i));

        // Backpressure then release.
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 8'h00, 1'b1, 8'h22, 1'b0, $sformatf("bp%0d", i));
        cycle(1'b0, 8'h00, 1'b1, 8'h22, 1'b1, "bp_rel");
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "drain2");

        // Mixed data words with random backpressure.
        for (int i = 0; i < 8; i++)
            cycle(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                  1'($urandom), $sformatf("rnd%0d", i));

        // Reset during contention; first grant afterwards goes to source 0.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, $sformatf("pre%0d", i));
        @(negedge CP);
        REQ0 = 1'b1; REQ1 = 1'b1; ZR = 1'b1;
        async_reset("rst_cont");
        cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, "post0");
        cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, "post1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
